// File: rtl/cnt_chk_pkg.sv
// Shared types and constants for the count checker tile.
package cnt_chk_pkg;

   // Lock state of the sequence follower.
   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_e;

   // uio_in bit positions.
   localparam int unsigned UIO_HOLD_BIT   = 0;
   localparam int unsigned UIO_CLR_BIT    = 1;
   localparam int unsigned UIO_SEL_BIT    = 2;

   // uio_out bit positions.
   localparam int unsigned UIO_LOCKED_BIT = 4;
   localparam int unsigned UIO_PULSE_BIT  = 5;
   localparam int unsigned UIO_LOSS_BIT   = 6;
   localparam int unsigned UIO_SAT_BIT    = 7;

   // Upper nibble of uio is driven, lower nibble is input-only.
   localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign sat   = &cnt_q;

endmodule

// File: rtl/tt_um_count_checker.sv
// Receiver for an 8-bit start/stop counter stream: predicts each next
// sample (hold or +1, wrapping), locks on the sequence, counts errors.
module tt_um_count_checker
   import cnt_chk_pkg::*;
#(
   parameter int unsigned LOCK_N = 4,
   parameter int unsigned MISS_N = 2
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);
   localparam logic [3:0] MISS_N_C = 4'(MISS_N);

   logic [7:0] s_q, s_d;
   logic       h_q, h_d;
   logic       ref_v_q, ref_v_d;
   state_e     state_q, state_d;
   logic [3:0] run_cnt_q, run_cnt_d;
   logic [3:0] miss_cnt_q, miss_cnt_d;
   logic       err_pulse_q, err_pulse_d;
   logic       loss_q, loss_d;

   logic [7:0] exp_v;
   logic       match;
   logic       clr;
   logic       sel;
   logic       err_inc;
   logic [7:0] err_cnt;
   logic       err_sat;

   assign clr   = uio_in[UIO_CLR_BIT];
   assign sel   = uio_in[UIO_SEL_BIT];
   // Hold sampled with a value means the next value repeats it.
   assign exp_v = h_q ? s_q : s_q + 8'd1;
   assign match = (ui_in == exp_v);

   // Sample capture, lock FSM, miss/run counting and loss flag.
   always_comb begin
      s_d         = ui_in;
      h_d         = uio_in[UIO_HOLD_BIT];
      ref_v_d     = 1'b1;
      state_d     = state_q;
      run_cnt_d   = run_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_pulse_d = 1'b0;
      loss_d      = loss_q;
      err_inc     = 1'b0;
      if (ref_v_q) begin
         case (state_q)
            ACQUIRE: begin
               if (match) begin
                  if (run_cnt_q + 4'd1 == LOCK_N_C) begin
                     state_d    = TRACK;
                     run_cnt_d  = 4'd0;
                     miss_cnt_d = 4'd0;
                  end else begin
                     run_cnt_d = run_cnt_q + 4'd1;
                  end
               end else begin
                  run_cnt_d = 4'd0;
               end
            end
            TRACK: begin
               if (match) begin
                  miss_cnt_d = 4'd0;
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  if (miss_cnt_q + 4'd1 == MISS_N_C) begin
                     state_d    = ACQUIRE;
                     loss_d     = 1'b1;
                     run_cnt_d  = 4'd0;
                     miss_cnt_d = 4'd0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = ACQUIRE;
         endcase
      end
      // Clear overrides a loss event in the same cycle.
      if (clr) begin
         loss_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q         <= 8'd0;
         h_q         <= 1'b0;
         ref_v_q     <= 1'b0;
         state_q     <= ACQUIRE;
         run_cnt_q   <= 4'd0;
         miss_cnt_q  <= 4'd0;
         err_pulse_q <= 1'b0;
         loss_q      <= 1'b0;
      end else begin
         s_q         <= s_d;
         h_q         <= h_d;
         ref_v_q     <= ref_v_d;
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_pulse_q <= err_pulse_d;
         loss_q      <= loss_d;
      end
   end

   sat_counter #(.W(8)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (err_inc),
      .count (err_cnt),
      .sat   (err_sat)
   );

   // Output mux and status bit packing.
   always_comb begin
      uo_out                  = sel ? s_q : err_cnt;
      uio_out                 = 8'h00;
      uio_out[UIO_LOCKED_BIT] = (state_q == TRACK);
      uio_out[UIO_PULSE_BIT]  = err_pulse_q;
      uio_out[UIO_LOSS_BIT]   = loss_q;
      uio_out[UIO_SAT_BIT]    = err_sat;
   end

   assign uio_oe = UIO_OE_MASK;

   logic _unused;
   assign _unused = &{1'b0, ena, uio_in[7:3], 1'b0};

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed bench for tt_um_count_checker: vector table plus corner sequences.
module tb_tt_um_count_checker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_count_checker dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ui;
    logic       hold;
    logic       clr;
    logic       sel;
    logic       locked;
    logic       pulse;
    logic       loss;
    logic [7:0] uo;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [7:0] ui, input logic hold, input logic clr,
                              input logic sel, input logic locked, input logic pulse,
                              input logic loss, input logic [7:0] uo);
    vec_t v;
    v.ui = ui; v.hold = hold; v.clr = clr; v.sel = sel;
    v.locked = locked; v.pulse = pulse; v.loss = loss; v.uo = uo;
    return v;
  endfunction

  function automatic logic [7:0] status(input logic sat, input logic loss,
                                        input logic pulse, input logic locked);
    return {sat, loss, pulse, locked, 4'b0000};
  endfunction

  // driver tasks
  task automatic drive(input logic [7:0] ui, input logic hold, input logic clr, input logic sel);
    ui_in  = ui;
    uio_in = {5'b00000, sel, clr, hold};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
    end
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] bad;
    int         exp_err;

    n_checks = 0;
    n_fail   = 0;
    ena      = 1'b1;
    rst_n    = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uo_err", uo_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'hF0);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("reset_uo_sample", uo_out, 8'h00);

    // Clean stream from 00: lock after edge 4, no errors
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(8'(k), 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("lock_seq_status_%0d", k), uio_out, status(1'b0, 1'b0, 1'b0, k >= 4));
      chk($sformatf("lock_seq_uo_%0d", k), uo_out, 8'h00);
    end

    // Table: wrap, hold alignment, glitch and re-lock
    tbl[0]  = mk(8'hF8, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mk(8'hF9, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[2]  = mk(8'hFA, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(8'hFB, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk(8'hFC, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[5]  = mk(8'hFD, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[6]  = mk(8'hFE, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[7]  = mk(8'hFF, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[8]  = mk(8'h00, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[9]  = mk(8'h01, 0, 0, 1, 1, 0, 0, 8'h01);
    tbl[10] = mk(8'h02, 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[11] = mk(8'h02, 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[12] = mk(8'h02, 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[13] = mk(8'h02, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[14] = mk(8'h03, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[15] = mk(8'h04, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[16] = mk(8'h05, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[17] = mk(8'h55, 0, 0, 0, 1, 1, 0, 8'h01);
    tbl[18] = mk(8'h07, 0, 0, 0, 0, 1, 1, 8'h02);
    tbl[19] = mk(8'h08, 0, 0, 0, 0, 0, 1, 8'h02);
    tbl[20] = mk(8'h09, 0, 0, 0, 0, 0, 1, 8'h02);
    tbl[21] = mk(8'h0A, 0, 0, 0, 0, 0, 1, 8'h02);
    tbl[22] = mk(8'h0B, 0, 0, 0, 1, 0, 1, 8'h02);
    tbl[23] = mk(8'h0C, 0, 0, 1, 1, 0, 1, 8'h0C);

    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].ui, tbl[i].hold, tbl[i].clr, tbl[i].sel);
      step();
      chk($sformatf("tbl_status_%0d", i), uio_out,
          status(1'b0, tbl[i].loss, tbl[i].pulse, tbl[i].locked));
      chk($sformatf("tbl_uo_%0d", i), uo_out, tbl[i].uo);
      chk($sformatf("tbl_oe_%0d", i), uio_oe, 8'hF0);
    end

    // 300 isolated mismatches while tracking: err_cnt saturates at FF
    cur     = 8'h0C;
    exp_err = 2;
    for (int k = 0; k < 300; k++) begin
      bad = cur ^ 8'h80;
      drive(bad, 1'b0, 1'b0, 1'b0);
      step();
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      chk($sformatf("sat_err_%0d", k), uo_out, 8'(exp_err));
      chk($sformatf("sat_status_%0d", k), uio_out,
          status(exp_err == 255, 1'b1, 1'b1, 1'b1));
      cur = bad + 8'd1;
      drive(cur, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat_final_status", uio_out, status(1'b1, 1'b1, 1'b0, 1'b1));
    chk("sat_final_err", uo_out, 8'hFF);

    // Clear together with a mismatch: clear wins over increment
    bad = cur ^ 8'h80;
    drive(bad, 1'b0, 1'b1, 1'b0);
    step();
    chk("clr_inc_err", uo_out, 8'h00);
    chk("clr_inc_status", uio_out, status(1'b0, 1'b0, 1'b1, 1'b1));

    // Clear together with the lock-dropping mismatch: loss stays 0
    cur = bad;
    bad = cur ^ 8'h80;
    drive(bad, 1'b0, 1'b1, 1'b0);
    step();
    chk("clr_loss_err", uo_out, 8'h00);
    chk("clr_loss_status", uio_out, status(1'b0, 1'b0, 1'b1, 1'b0));

    // Re-lock, then accumulate exactly 5 errors
    cur = bad;
    for (int k = 0; k < 4; k++) begin
      cur = cur + 8'd1;
      drive(cur, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("relock_status", uio_out, status(1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++) begin
      bad = cur ^ 8'h80;
      drive(bad, 1'b0, 1'b0, 1'b0);
      step();
      cur = bad + 8'd1;
      drive(cur, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("five_err_cnt", uo_out, 8'h05);
    chk("five_err_status", uio_out, status(1'b0, 1'b0, 1'b0, 1'b1));

    // One-cycle reset mid-TRACK
    rst_n = 1'b0;
    drive(cur + 8'd1, 1'b0, 1'b0, 1'b0);
    step();
    chk("midrst_status", uio_out, 8'h00);
    chk("midrst_err", uo_out, 8'h00);
    chk("midrst_oe", uio_oe, 8'hF0);
    drive(cur + 8'd1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("midrst_sample", uo_out, 8'h00);

    // Back in ACQUIRE: needs the full lock latency again
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(8'h20 + 8'(k), 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("post_rst_lock_%0d", k), uio_out, status(1'b0, 1'b0, 1'b0, k == 4));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_count_checker.md
# tt_um_count_checker

Receiving end of the tile's 8-bit start/stop counter stream. The block samples an external counter's value on `ui_in` and that counter's stop line on `uio_in[0]`, then predicts each next value (hold or +1, modulo 256). It acquires lock on the sequence, counts mismatches in a saturating error counter, and reports lock and loss status. It sits as a standalone Tiny Tapeout user tile and can be wired back-to-back with the counter tile for bring-up.

## Interface
Parameters:
- `LOCK_N`, default 4: consecutive matching samples needed to enter TRACK (legal range 1–15).
- `MISS_N`, default 2: consecutive mismatches in TRACK that drop lock (legal range 1–15).

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: reset. **Synchronous, active-low.**
- `ena`, input, 1: always 1 when powered; unused.
- `ui_in`, input, 8: observed counter value.
- `uio_in`, input, 8:
  - [0]: source hold (1 = stopped).
  - [1]: clear errors.
  - [2]: `uo_out` select (0 = error count, 1 = last sample).
  - [7:3]: unused.
- `uo_out`, output, 8: `err_cnt` or `s_q`, as selected by `uio_in[2]`.
- `uio_out`, output, 8:
  - [4]: locked.
  - [5]: err_pulse.
  - [6]: loss (sticky).
  - [7]: err_sat.
  - [3:0]: 0.
- `uio_oe`, output, 8: constant `8'hF0`.

## Operation
- Registers: `s_q` (last sample), `h_q` (last hold), `ref_v` (reference valid), `state`, `run_cnt` (4b), `miss_cnt` (4b), `err_cnt` (8b), `err_pulse`, `loss`.
- Expected value: `exp = h_q ? s_q : s_q + 1`, 8-bit wrap, so `FF` is followed by `00`. Match: `ui_in == exp`.
- Every cycle out of reset: `s_q <= ui_in`, `h_q <= uio_in[0]`, `ref_v <= 1`.
- While `ref_v == 0` (first cycle after reset), no comparison is made.
- State ACQUIRE:
  - Match: `run_cnt++`. When `run_cnt + 1 == LOCK_N`, go to TRACK and clear `run_cnt` and `miss_cnt`.
  - Mismatch: `run_cnt <= 0`.
  - `err_cnt` is never incremented and `err_pulse` stays 0.
- State TRACK:
  - Match: `miss_cnt <= 0`.
  - Mismatch: `err_pulse <= 1`, `err_cnt` increments and saturates at `FF`, `miss_cnt++`.
  - When `miss_cnt + 1 == MISS_N`: go to ACQUIRE, set `loss <= 1`, clear `run_cnt`.
- The sample that caused a mismatch becomes the new `s_q`, so re-acquire starts from the new value.
- `err_pulse` is 0 on every cycle without a TRACK mismatch.
- Clear (`uio_in[1] = 1`):
  - `err_cnt <= 0` and `loss <= 0`.
  - Clear has priority over an increment or loss event in the same cycle.
  - The FSM, `err_pulse` and lock are unaffected.
- Outputs:
  - `locked = (state == TRACK)`.
  - `err_sat = (err_cnt == FF)`.
  - `uo_out` mux is combinational on `uio_in[2]`.
- Reset (`rst_n` low at a clock edge, including mid-TRACK):
  - All registers go to 0, state goes to ACQUIRE.
  - All outputs read 0, except that `uo_out` shows `err_cnt` or `s_q`, both 0.

## Timing
- All state changes happen at `posedge clk`. No combinational path from inputs to status bits.
- Sample presented in cycle t:
  - Its compare result appears on `err_pulse` and `err_cnt` in cycle t+1.
  - `locked` and `loss` update in cycle t+1.
- Lock latency from the first edge with `rst_n` high, on a clean incrementing stream: the first sample is captured at edge 0 and `locked` rises after edge `LOCK_N`, i.e. edge 4 by default.
- Hold is interpreted with one-sample alignment: the hold level sampled alongside value v predicts the value that follows v. This matches a counter whose next state uses its current stop input.
- Loss latency: `locked` falls on the cycle after the `MISS_N`-th consecutive mismatch.

## Structure
- Package `cnt_chk_pkg` contains:
  - State enum `{ACQUIRE, TRACK}`.
  - `uio` bit-index constants.
  - `UIO_OE_MASK = 8'hF0`.
- Sub-module `sat_counter`: 8-bit saturating up-counter with sync clear (clear priority over increment) and inc enable. It is instantiated for `err_cnt`.
- Top level contains the sample registers, the expectation compare, the FSM and the output mux.
- Tie off `ena` and the unused `uio_in` bits in an `_unused` reduction.

## Test plan
- Reset, then `ui_in` = 00, 01, 02, … with hold 0. Expect:
  - `locked` = 1 after edge 4.
  - `err_cnt` stays 0.
  - `uo_out` = 00 throughout.
- Locked with stream …FE, FF, 00, 01. Expect:
  - Wrap is accepted: no `err_pulse`, `locked` stays 1.
- Locked, hold = 1 during sample 10, then the stream repeats 10 for 3 cycles, then continues with 11. Expect:
  - Zero errors.
  - The first mismatch check is against 10, not 11.
- Locked, inject one glitch (07, 08, 55, 0A). Expect:
  - Sample 55 mismatches: `err_pulse` for 1 cycle, `err_cnt` = 1.
  - Sample 0A mismatches against 56: `miss_cnt` reaches 2, so `locked` = 0 and `loss` = 1. Total `err_cnt` = 2.
  - Re-lock from 0A follows after 4 clean samples.
- Force 300 mismatches while in TRACK, lock recovering each time. Expect:
  - `err_cnt` saturates at FF and `err_sat` = 1.
  - Assert clear together with a mismatch: `err_cnt` = 00, `loss` = 0.
- Assert `rst_n` = 0 for 1 cycle mid-TRACK with `err_cnt` = 5. Expect:
  - Next cycle: all `uio_out` status bits 0, `err_cnt` = 0, state ACQUIRE.
  - `uio_oe` stays F0.
